// File: rtl/seq_detect_prog_if.sv
// Config and serial-stream bundle for seq_detect_prog.
// The master side drives config and bits; the detector returns match/status.
interface seq_detect_prog_if #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 16
);
  localparam int LW = $clog2(MAX_LEN + 1);

  logic               cfg_we;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LW-1:0]      cfg_len;
  logic               cfg_overlap;
  logic               cfg_err;
  logic               in_valid;
  logic               x;
  logic               match;
  logic [CNT_W-1:0]   match_count;

  modport master (
    output cfg_we, cfg_pattern, cfg_len, cfg_overlap, in_valid, x,
    input  cfg_err, match, match_count
  );

  modport slave (
    input  cfg_we, cfg_pattern, cfg_len, cfg_overlap, in_valid, x,
    output cfg_err, match, match_count
  );
endinterface

// File: rtl/seq_detect_prog.sv
// Programmable serial bit-pattern detector with run-time pattern, length and
// overlap mode; flags and counts each occurrence in the qualified stream.
module seq_detect_prog #(
  parameter int                   MAX_LEN         = 8,
  parameter logic [MAX_LEN-1:0]   DEFAULT_PATTERN = 8'b0000_0110,
  parameter int                   DEFAULT_LEN     = 3,
  parameter int                   CNT_W           = 16,
  parameter bit                   MEALY           = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  seq_detect_prog_if.slave  bus
);
  localparam int LW = $clog2(MAX_LEN + 1);

  // Only MAX_LEN-1 history bits are needed: the current bit completes the window.
  logic [MAX_LEN-2:0] hist_reg, hist_next;
  logic [LW-1:0]      fill_reg, fill_next;
  logic [MAX_LEN-1:0] pat_reg,  pat_next;
  logic [LW-1:0]      len_reg,  len_next;
  logic               ovl_reg,  ovl_next;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic               match_reg, match_next;
  logic               err_reg,  err_next;

  logic [MAX_LEN-1:0] window;
  logic [MAX_LEN-1:0] bit_ok;
  logic [LW:0]        fill_inc;
  logic               accept;
  logic               fill_ok;
  logic               hit;
  logic               cfg_ok;

  assign window   = {hist_reg, bus.x};
  assign fill_inc = {1'b0, fill_reg} + (LW+1)'(1);
  assign fill_ok  = fill_inc >= {1'b0, len_reg};
  assign accept   = bus.in_valid & ~bus.cfg_we & ~rst;
  assign cfg_ok   = (bus.cfg_len != '0) && (bus.cfg_len <= LW'(MAX_LEN));

  // Positions at or above len are don't-care, so they always compare true.
  genvar gi;
  generate
    for (gi = 0; gi < MAX_LEN; gi++) begin : g_cmp
      assign bit_ok[gi] = (LW'(gi) >= len_reg) || (window[gi] == pat_reg[gi]);
    end
  endgenerate

  assign hit = accept & fill_ok & (&bit_ok);

  always_comb begin
    hist_next  = hist_reg;
    fill_next  = fill_reg;
    pat_next   = pat_reg;
    len_next   = len_reg;
    ovl_next   = ovl_reg;
    count_next = count_reg;
    match_next = 1'b0;
    err_next   = 1'b0;
    if (bus.cfg_we) begin
      // A config cycle never consumes the offered bit, valid or not.
      if (cfg_ok) begin
        pat_next   = bus.cfg_pattern;
        len_next   = bus.cfg_len;
        ovl_next   = bus.cfg_overlap;
        hist_next  = '0;
        fill_next  = '0;
        count_next = '0;
      end else begin
        err_next = 1'b1;
      end
    end else if (bus.in_valid) begin
      hist_next = window[MAX_LEN-2:0];
      fill_next = (fill_reg == LW'(MAX_LEN)) ? fill_reg : fill_inc[LW-1:0];
      if (hit) begin
        match_next = 1'b1;
        count_next = (count_reg == '1) ? count_reg : count_reg + CNT_W'(1);
        if (!ovl_reg) fill_next = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_reg  <= '0;
      fill_reg  <= '0;
      pat_reg   <= DEFAULT_PATTERN;
      len_reg   <= LW'(DEFAULT_LEN);
      ovl_reg   <= 1'b1;
      count_reg <= '0;
      match_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      hist_reg  <= hist_next;
      fill_reg  <= fill_next;
      pat_reg   <= pat_next;
      len_reg   <= len_next;
      ovl_reg   <= ovl_next;
      count_reg <= count_next;
      match_reg <= match_next;
      err_reg   <= err_next;
    end
  end

  assign bus.match       = MEALY ? hit : match_reg;
  assign bus.match_count = count_reg;
  assign bus.cfg_err     = err_reg;
endmodule

// File: doc/seq_detect_prog.md
# seq_detect_prog

Programmable serial bit-pattern detector: the next generation of the team's fixed 3-bit "110" detectors. Pattern, pattern length (1..MAX_LEN) and overlap mode are loaded at run time through a config port. A qualified serial input stream is compared against the pattern, and each occurrence is flagged and counted. It sits between a serial front end and status/interrupt logic and replaces per-pattern hard-coded FSMs.

## Interface
- MAX_LEN, 8: maximum pattern length in bits (>=2).
- DEFAULT_PATTERN, 8'b0000_0110: pattern after reset (MAX_LEN wide, right-aligned).
- DEFAULT_LEN, 3: pattern length after reset (1..MAX_LEN).
- CNT_W, 16: match counter width.
- MEALY, 0: 0 = registered match output; 1 = combinational match output.
- LW (derived), $clog2(MAX_LEN+1): width of length fields.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- cfg_we  in  1  config load strobe.
- cfg_pattern  in  MAX_LEN  new pattern, right-aligned; bit [len-1] is the first bit received, bit [0] the last.
- cfg_len  in  LW  new pattern length.
- cfg_overlap  in  1  1 = overlapping matches allowed; 0 = non-overlapping.
- cfg_err  out  1  one-cycle pulse: rejected config.
- in_valid  in  1  x is sampled only when high.
- x  in  1  serial data bit.
- match  out  1  pattern-completion flag.
- match_count  out  CNT_W  saturating number of matches.

## Operation
- State: hist[MAX_LEN-1:0], fill (0..MAX_LEN, saturating), pat, len, ovl, match_count.
- Accepted bit: the bit x on any cycle with in_valid=1 and cfg_we=0. On each accepted bit:
  - hist <= {hist[MAX_LEN-2:0], x}.
  - fill <= min(fill+1, MAX_LEN).
- hit, combinational: accepted bit AND (fill+1 >= len) AND ({hist, x} low len bits == pat low len bits). Bits above len in pat and hist are ignored.
- On hit:
  - match_count increments, saturating at all-ones.
  - If ovl=0, fill <= 0: bits of the matched occurrence cannot start another match.
  - If ovl=1, fill follows the normal rule.
- Valid config load (cfg_we=1, 1 <= cfg_len <= MAX_LEN):
  - pat, len and ovl are loaded.
  - hist, fill and match_count are cleared.
  - in_valid/x are ignored that cycle.
- Invalid config load (cfg_len=0 or cfg_len > MAX_LEN):
  - All config and datapath state is unchanged.
  - cfg_err=1 for one cycle.
  - The bit offered that cycle is still dropped.
- Reset values: pat=DEFAULT_PATTERN, len=DEFAULT_LEN, ovl=1, hist=0, fill=0, match=0, match_count=0, cfg_err=0.
- Reset has priority over cfg_we and in_valid. Reset mid-stream discards any partial match.

## Timing
- MEALY=0: match is registered and is high for exactly one cycle, the cycle after the accepted bit that completes the pattern. match_count updates on the same edge.
- MEALY=1: match = hit, in the same cycle as the completing bit. match_count still updates on the following edge.
- Back-to-back matches on consecutive accepted bits give consecutive match pulses. Example: len=1 gives one pulse per matching bit.
- Gaps in in_valid do not break a partial match; only accepted bits advance state.
- cfg_err is registered: it is high the cycle after the offending cfg_we.
- New config takes effect for the first accepted bit after the load edge.
- Throughput: one bit per clock with no stalls.

## Test plan
- Default config after reset, in_valid=1, stream 1,1,0,1,1,0,0,1,1,0 -> match pulses after bits 3, 6 and 10; match_count=3.
- Load pattern 4'b1011, len=4, overlap=1; stream 1,0,1,1,0,1,1 -> matches after bits 4 and 7; count=2. Reload with overlap=0 and the same stream -> one match, after bit 4; count=1.
- Default 110 pattern with in_valid low for 3 cycles between each bit -> same match positions relative to accepted bits; match never asserts on idle cycles.
- cfg_len=0, then cfg_len=9 (MAX_LEN=8) -> cfg_err pulses each time; the default 110 pattern is still detected afterwards and match_count is not cleared.
- CNT_W=2, len=1, pattern 1, stream of six 1s -> six match pulses; match_count sticks at 3.
- Assert rst after bits 1,1 of 110, then send 0 -> no match. Then send 1,1,0 -> match; count=1. Repeat with MEALY=1 and check match coincides with the final 0.
